prob_argmax: RTL
================

PROB_ARGMAX -- requirements
Module: prob_argmax

Interface
REQ-001 The block SHALL have parameter NUM_CLASSES, default 10, number of class scores.
REQ-002 The block SHALL have parameter SCORE_W, default 113, signed width of one class score.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-005 The block SHALL have port start, input, 1, request to classify the current prob_in.
REQ-006 The block SHALL have port prob_in, input, NUM_CLASSES*SCORE_W (1130), packed signed scores, class k at bits [k*SCORE_W+SCORE_W-1 : k*SCORE_W].
REQ-007 The block SHALL have port busy, output, 1, high while a classification is in progress.
REQ-008 The block SHALL have port done, output, 1, one-cycle pulse when the outputs are valid.
REQ-009 The block SHALL have port result, output, 4, index of the winning class.
REQ-010 The block SHALL have port max_score, output, SCORE_W, signed score of the winning class.
REQ-011 The block SHALL have port margin, output, SCORE_W+1, unsigned max_score minus second-highest score.

Function
REQ-012 The FSM SHALL have states IDLE, SCAN and DONE.
REQ-013 In IDLE, start=1 at an edge SHALL latch all of prob_in, set best=class 0, best_idx=0, second=-2^(SCORE_W-1), idx=1, and go to SCAN.
REQ-014 In SCAN, each edge SHALL compare exactly one latched class idx, signed: if p[idx] > best then second<=best, best<=p[idx], best_idx<=idx; else if p[idx] > second then second<=p[idx].
REQ-015 Ties SHALL resolve to the lowest index: strict greater-than only, and an equal score lands in second, giving margin 0.
REQ-016 SCAN SHALL move to DONE after comparing idx=NUM_CLASSES-1; otherwise idx increments.
REQ-017 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-018 done SHALL assert in the 10th cycle after the edge that sampled start (NUM_CLASSES edges total).
REQ-019 result, max_score and margin SHALL update only on entry to DONE and hold until the next DONE or reset.
REQ-020 margin SHALL be computed as best - second in SCORE_W+1 bits with no overflow.
REQ-021 busy SHALL be 1 in SCAN and DONE and 0 in IDLE.
REQ-022 start SHALL be ignored while busy=1.
REQ-023 prob_in changes after the start edge SHALL NOT affect the result.
REQ-024 Back-to-back starts SHALL be allowed: start high during the IDLE cycle right after DONE begins a new scan.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE, with busy=0, done=0, result=0, max_score=0, margin=0, and clear idx, best and second.
REQ-026 rst asserted mid-SCAN or in DONE SHALL abort with no done pulse, and rst SHALL take priority over start in the same cycle.

Structure
REQ-027 NUM_CLASSES, SCORE_W and the FSM state encoding SHALL live in shared package cnn_pkg, reused by simpleCNN.
REQ-028 No sub-module SHALL be required; the comparator and update logic SHALL be inline, and the latched score array SHALL be indexed by idx through a single NUM_CLASSES:1 mux.

Verification
REQ-029 The bench SHALL cover: scores 0..9 = {5,-3,7,2,7,0,1,-9,6,4}, start pulse -> done exactly 10 cycles later, result=2, max_score=7, margin=0.
REQ-030 The bench SHALL cover: all scores -100 except class 9 = -1 -> result=9, max_score=-1, margin=99.
REQ-031 The bench SHALL cover: class 0 = 2^112-1 and class 1 = -2^112, others 0 -> result=0, margin=2^112-1 with no overflow.
REQ-032 The bench SHALL cover: start held high 25 cycles -> exactly two done pulses, 11 cycles apart, with busy=1 throughout except the IDLE cycle between them.
REQ-033 The bench SHALL cover: rst at cycle 4 of SCAN -> no done pulse, all outputs 0 next cycle; a new start then completes normally.
REQ-034 The bench SHALL cover: prob_in changed every cycle after start -> result matches the scores latched at start.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared constants and FSM encoding for the classifier tail (argmax over class scores).
package cnn_pkg;
    localparam int CNN_NUM_CLASSES = 10;
    localparam int CNN_SCORE_W     = 113;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/prob_argmax.sv
// Sequential argmax: latches all class scores on start, scans one class per cycle,
// reports winning index, its score and the margin over the runner-up.
module prob_argmax
    import cnn_pkg::*;
#(
    parameter int NUM_CLASSES = CNN_NUM_CLASSES,
    parameter int SCORE_W     = CNN_SCORE_W
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [NUM_CLASSES*SCORE_W-1:0] prob_in,
    output logic                           busy,
    output logic                           done,
    output logic [3:0]                     result,
    output logic [SCORE_W-1:0]             max_score,
    output logic [SCORE_W:0]               margin
);
    localparam int IDX_W = 4;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CLASSES - 1);
    localparam logic signed [SCORE_W-1:0] MOST_NEG = {1'b1, {(SCORE_W-1){1'b0}}};

    state_t state_q, state_d;

    logic [NUM_CLASSES-1:0][SCORE_W-1:0] lat;
    logic [IDX_W-1:0]                    idx;
    logic [IDX_W-1:0]                    best_idx;
    logic signed [SCORE_W-1:0]           best;
    logic signed [SCORE_W-1:0]           second;

    logic signed [SCORE_W-1:0] cur;
    logic signed [SCORE_W-1:0] nbest;
    logic signed [SCORE_W-1:0] nsecond;
    logic [IDX_W-1:0]          nbest_idx;
    logic                      accept;

    assign accept = (state_q == ST_IDLE) && start;
    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_SCAN;
            ST_SCAN: if (idx == LAST) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Single NUM_CLASSES:1 mux into one comparator pair; strict > keeps the lowest index on ties.
    always_comb begin
        cur       = lat[idx];
        nbest     = best;
        nsecond   = second;
        nbest_idx = best_idx;
        if (cur > best) begin
            nsecond   = best;
            nbest     = cur;
            nbest_idx = idx;
        end else if (cur > second) begin
            nsecond = cur;
        end
    end

    // Score storage needs no reset: it is always reloaded before it is read.
    always_ff @(posedge clk) begin
        if (accept) lat <= prob_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            best_idx  <= '0;
            best      <= '0;
            second    <= '0;
            result    <= '0;
            max_score <= '0;
            margin    <= '0;
        end else if (accept) begin
            best     <= prob_in[SCORE_W-1:0];
            best_idx <= '0;
            second   <= MOST_NEG;
            idx      <= IDX_W'(1);
        end else if (state_q == ST_SCAN) begin
            best     <= nbest;
            second   <= nsecond;
            best_idx <= nbest_idx;
            idx      <= idx + IDX_W'(1);
            if (idx == LAST) begin
                result    <= nbest_idx;
                max_score <= nbest;
                // best >= second always, so the widened difference is non-negative.
                margin    <= {nbest[SCORE_W-1], nbest} - {nsecond[SCORE_W-1], nsecond};
            end
        end
    end
endmodule
